// File: rtl/issue_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// issue_scoreboard_pkg : shared encodings, pipe depths and issue bundle type
// Revision 1.0
// ============================================================================
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_X    = 2'd1,
    FU_M    = 2'd2,
    FU_RSVD = 2'd3
  } fu_e;

  // Default writeback depths; the X and M pipes are built against these.
  localparam int DEF_X_WB_CYCLES = 5;
  localparam int DEF_M_WB_CYCLES = 6;

  localparam int CNT_W  = 3;
  localparam int WB_W   = 2 ** CNT_W;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [1:0]        functionalunit;
    logic              selalushift;
    logic              selimregb;
    logic [2:0]        aluop;
    logic              unsig;
    logic [1:0]        shiftop;
    logic [4:0]        shiftamt;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic [DATA_W-1:0] imedext;
    logic [REG_W-1:0]  regdest;
    logic              writereg;
    logic              writeov;
  } issue_t;

  function automatic logic fu_is_valid(input logic [1:0] fu);
    return (fu == FU_X) || (fu == FU_M);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard_regs.sv
`default_nettype none
// ============================================================================
// issue_scoreboard_regs : per-register pending-write counters and the shared
// writeback-port reservation vector
// Revision 1.0
// ============================================================================
module issue_scoreboard_regs
  import issue_scoreboard_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_wr,
  input  logic [REG_W-1:0] regdest,
  input  logic [CNT_W-1:0] lat,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             rs_ready,
  output logic             rt_ready,
  output logic             waw_cmp,
  output logic             port_busy
);

  logic [CNT_W-1:0] pend_q [NREGS];
  logic [CNT_W-1:0] pend_d [NREGS];
  logic [WB_W-1:0]  wb_slot_q;
  logic [WB_W-1:0]  wb_slot_d;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - CNT_W'(1) : '0;
    end
    pend_d[0] = '0;
    // A fresh load wins over the decrement of the same register.
    if (issue_wr && (regdest != '0)) begin
      pend_d[regdest] = lat;
    end
    wb_slot_d = wb_slot_q >> 1;
    if (issue_wr) begin
      wb_slot_d[lat] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
      wb_slot_q <= '0;
    end else begin
      pend_q    <= pend_d;
      wb_slot_q <= wb_slot_d;
    end
  end

  assign rs_ready = (pend_q[rs] == '0);
  assign rt_ready = (pend_q[rt] == '0);
  assign waw_cmp  = (pend_q[regdest] > lat);
  // Slot L+1 now becomes slot L after this edge's shift.
  assign port_busy = (lat == '1) ? 1'b0 : wb_slot_q[lat + CNT_W'(1)];

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// issue_scoreboard : in-order issue stage with RAW/WAW/write-port interlocks
// Revision 1.0
// ============================================================================
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int X_WB_CYCLES = DEF_X_WB_CYCLES,
  parameter int M_WB_CYCLES = DEF_M_WB_CYCLES,
  parameter int NREGS       = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [1:0]  id_is_functionalunit,
  input  logic [4:0]  id_is_rs,
  input  logic [4:0]  id_is_rt,
  input  logic        id_is_usesrs,
  input  logic        id_is_usesrt,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic        id_is_writeov,
  input  logic        id_is_selalushift,
  input  logic        id_is_selimregb,
  input  logic        id_is_unsig,
  input  logic [2:0]  id_is_aluop,
  input  logic [1:0]  id_is_shiftop,
  input  logic [4:0]  id_is_shiftamt,
  input  logic [31:0] id_is_imedext,
  output logic [4:0]  is_rf_rs,
  output logic [4:0]  is_rf_rt,
  input  logic [31:0] rf_is_rega,
  input  logic [31:0] rf_is_regb,
  output logic        is_id_stall,
  output logic [1:0]  is_x_functionalunit,
  output logic        is_x_selalushift,
  output logic        is_x_selimregb,
  output logic [2:0]  is_x_aluop,
  output logic        is_x_unsig,
  output logic [1:0]  is_x_shiftop,
  output logic [4:0]  is_x_shiftamt,
  output logic [31:0] is_x_rega,
  output logic [31:0] is_x_regb,
  output logic [31:0] is_x_imedext,
  output logic [4:0]  is_x_regdest,
  output logic        is_x_writereg,
  output logic        is_x_writeov
);

  localparam logic [CNT_W-1:0] X_LAT = CNT_W'(X_WB_CYCLES);
  localparam logic [CNT_W-1:0] M_LAT = CNT_W'(M_WB_CYCLES);

  logic [CNT_W-1:0] lat;
  logic             valid;
  logic             rs_ready;
  logic             rt_ready;
  logic             waw_cmp;
  logic             port_busy;
  logic             raw;
  logic             waw;
  logic             port;
  logic             stall;
  logic             fire;
  issue_t           issue_d;
  issue_t           issue_q;

  assign lat   = (id_is_functionalunit == FU_M) ? M_LAT : X_LAT;
  assign valid = id_is_valid && fu_is_valid(id_is_functionalunit);

  issue_scoreboard_regs #(
    .NREGS (NREGS)
  ) u_regs (
    .clock     (clock),
    .reset     (reset),
    .issue_wr  (fire && id_is_writereg),
    .regdest   (id_is_regdest),
    .lat       (lat),
    .rs        (id_is_rs),
    .rt        (id_is_rt),
    .rs_ready  (rs_ready),
    .rt_ready  (rt_ready),
    .waw_cmp   (waw_cmp),
    .port_busy (port_busy)
  );

  assign raw   = (id_is_usesrs && !rs_ready) || (id_is_usesrt && !rt_ready);
  assign waw   = id_is_writereg && waw_cmp;
  assign port  = id_is_writereg && port_busy;
  assign stall = valid && (raw || waw || port);
  assign fire  = valid && !stall;

  assign is_id_stall = stall;
  assign is_rf_rs    = id_is_rs;
  assign is_rf_rt    = id_is_rt;

  always_comb begin
    issue_d = '0;
    if (fire) begin
      issue_d.functionalunit = id_is_functionalunit;
      issue_d.selalushift    = id_is_selalushift;
      issue_d.selimregb      = id_is_selimregb;
      issue_d.aluop          = id_is_aluop;
      issue_d.unsig          = id_is_unsig;
      issue_d.shiftop        = id_is_shiftop;
      issue_d.shiftamt       = id_is_shiftamt;
      issue_d.rega           = rf_is_rega;
      issue_d.regb           = rf_is_regb;
      issue_d.imedext        = id_is_imedext;
      issue_d.regdest        = id_is_regdest;
      issue_d.writereg       = id_is_writereg;
      issue_d.writeov        = id_is_writeov;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_q <= '0;
    end else begin
      issue_q <= issue_d;
    end
  end

  assign is_x_functionalunit = issue_q.functionalunit;
  assign is_x_selalushift    = issue_q.selalushift;
  assign is_x_selimregb      = issue_q.selimregb;
  assign is_x_aluop          = issue_q.aluop;
  assign is_x_unsig          = issue_q.unsig;
  assign is_x_shiftop        = issue_q.shiftop;
  assign is_x_shiftamt       = issue_q.shiftamt;
  assign is_x_rega           = issue_q.rega;
  assign is_x_regb           = issue_q.regb;
  assign is_x_imedext        = issue_q.imedext;
  assign is_x_regdest        = issue_q.regdest;
  assign is_x_writereg       = issue_q.writereg;
  assign is_x_writeov        = issue_q.writeov;

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order issue stage sitting directly upstream of the X execute pipe and the M (memory) pipe.
- Accepts one decoded instruction per cycle from decode and checks RAW, WAW and writeback-port hazards against a per-register scoreboard.
- Reads operands from the register file and launches the instruction on the registered is_x_* bundle, or inserts a bubble and stalls decode.
- Both pipes share one register-file write port, so writeback slots are reserved at issue time.

Parameters:
- X_WB_CYCLES, 5: clock edges from the issue-register load to the register-file write, for X-unit ops (1 to 7).
- M_WB_CYCLES, 6: same, for M-unit ops (1 to 7).
- NREGS, 32: architectural registers; r0 is hardwired zero.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_is_valid  in  1  decode presents an instruction.
- id_is_functionalunit  in  2  1=X, 2=M; 0 and 3 treated as not valid.
- id_is_rs, id_is_rt  in  5 each  source register indices.
- id_is_usesrs, id_is_usesrt  in  1 each  source actually read.
- id_is_regdest  in  5  destination register.
- id_is_writereg  in  1  instruction writes regdest.
- id_is_writeov  in  1  write even on overflow.
- id_is_selalushift, id_is_selimregb, id_is_unsig  in  1 each  pass-through controls.
- id_is_aluop  in  3  pass-through.
- id_is_shiftop  in  2  pass-through.
- id_is_shiftamt  in  5  pass-through.
- id_is_imedext  in  32  pass-through.
- is_rf_rs, is_rf_rt  out  5 each  register-file read addresses (combinational copies of id_is_rs and id_is_rt).
- rf_is_rega, rf_is_regb  in  32 each  register-file read data (combinational).
- is_id_stall  out  1  combinational; decode holds its instruction while high.
- is_x_functionalunit, is_x_selalushift, is_x_selimregb, is_x_aluop, is_x_unsig, is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb, is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov  out  same widths as their id_is/rf_is sources  registered issue bundle to the execute pipes.

Behaviour:
- Reset (asynchronous, active-high):
  - All is_x_* outputs go to 0, so functionalunit=0, which is a bubble.
  - All scoreboard counters and the wb_slot vector are cleared.
  - A reset mid-operation discards in-flight tracking; the downstream pipes are reset by the same signal.
- Latency: L = X_WB_CYCLES or M_WB_CYCLES, selected by id_is_functionalunit.
- Scoreboard: pend[r], 3 bits, for r = 1..NREGS-1. pend[0] always reads 0.
  - Every edge, each nonzero counter decrements by 1.
  - On an issue with writereg=1 and regdest≠0, pend[regdest] loads L instead (the load overrides the decrement).
  - A register is ready when pend = 0; the register file was written on that edge and a combinational read returns the new value.
  - There is no bypassing.
- Writeback reservation: wb_slot, 8 bits. Bit k set means the write port is used k edges from now.
  - Every edge the vector shifts right by 1.
  - On an issue with writereg=1, bit L is also set after the shift.
- Hazards, evaluated combinationally when the instruction is valid:
  - raw = (usesrs & pend[rs]≠0) | (usesrt & pend[rt]≠0).
  - waw = writereg & pend[regdest] > L.
  - port = writereg & wb_slot[L+1].
  - is_id_stall = valid & (raw | waw | port).
- Issue (valid & !stall): the issue register loads the id_is_* fields, rega from rf_is_rega and regb from rf_is_regb.
- Stall or invalid: the issue register loads a bubble, with functionalunit=0, writereg=0, writeov=0 and regdest=0. The data fields are don't-care and are driven 0.
- Simultaneous events: a decrement to 0 and a new load on the same register in the same edge gives the load value.
- Decode holding a stalled instruction re-evaluates every cycle. The issue is the first cycle with no hazard.

Decomposition:
- Shared package holds:
  - the functional-unit encoding constants (FU_NONE=0, FU_X=1, FU_M=2);
  - X_WB_CYCLES and M_WB_CYCLES as defaults, so the X and M pipe depths stay consistent with them;
  - the 3-bit counter width.
- One natural sub-module, scoreboard_regs:
  - holds the pend[] array and wb_slot;
  - takes the issue strobe, regdest and L;
  - returns per-source ready, the WAW compare and the port-busy flag.
- The top level contains the hazard OR and the issue register.

Test Plan:
- Reset: assert reset mid-run while pend[5]=3 -> all is_x_* = 0 immediately, and after release a reader of r5 issues with no stall.
- Independent X ops r1<-r2+r3 then r4<-r6+r7 back-to-back -> both issue on consecutive edges, is_id_stall stays 0, and is_x_functionalunit = 1,1.
- RAW: X op writing r8 issued at edge E0, next op reads r8 -> is_id_stall high for 5 cycles with bubbles issued, consumer issues at E6 and is_x_rega equals the written value.
- Port conflict: M op (L=6) issued at E0 writing r9, then X op (L=5) writing r10 -> X stalls exactly 1 cycle, and the two writes land on distinct edges E6 and E7.
- WAW: M op writing r11 at E0, then X op writing r11 -> the X op is held until pend[r11] ≤ 5; the X writeback lands after the M writeback, and the final r11 equals the X result.
- r0: op with writereg=1 and regdest=0, followed by a reader of r0 -> no stall and pend is unchanged; id_is_valid=0 -> bubble, no stall, no wb_slot bit set.
